mdio_controller: RTL and testbench
==================================

# mdio_controller

Station-management (host-side) MDIO frame generator that sits directly upstream of the MDIO receptor/PHY model. It accepts a 32-bit transaction word from the host and serialises it onto MDIO_OUT/MDIO_OE, clocked by a self-generated MDC. For read frames it releases the bus after the command half and captures the 16 returned data bits from MDIO_IN into RD_DATA.

## Interface
- MDC_HALF, default 1: MDC half-period in CLK cycles (≥1); MDC period = 2·MDC_HALF CLK cycles.
- CLK  input  1  system clock; all state updates on posedge CLK.
- RESET  input  1  reset, synchronous, active-low; one clock; reset is synchronous and active-low.
- MDIO_START  input  1  transaction request, sampled on every CLK edge.
- T_DATA  input  32  frame: [31:30] ST, [29:28] OP (01 write, 10 read), [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] data (ignored for read).
- MDIO_IN  input  1  serial read data from PHY side.
- MDC  output  1  management clock, free-running after reset.
- MDIO_OUT  output  1  serial frame data, MSB (T_DATA[31]) first.
- MDIO_OE  output  1  high while the controller drives MDIO_OUT.
- RD_DATA  output  16  last completed read data, MSB first as received.
- DATA_RDY  output  1  one-CLK pulse when RD_DATA updates.
- BUSY  output  1  high from START acceptance until the frame ends.

## Operation
- Reset (RESET=0 at a CLK edge): MDC=0, MDIO_OUT=0, MDIO_OE=0, RD_DATA=0, DATA_RDY=0, BUSY=0, divider and bit counter=0, state IDLE. Applies mid-frame; frame is abandoned, no DATA_RDY.
- Divider: MDC toggles when div_cnt reaches MDC_HALF-1, then div_cnt=0. "Falling tick" = CLK edge at which MDC goes 1→0; "rising tick" = 0→1.
- States: IDLE, ARM, DRIVE, RELEASE_RD.
- IDLE: MDIO_START=1 latches T_DATA into shift register, op_rd=(T_DATA[29:28]==2'b10), BUSY=1, → ARM. START while BUSY=1 is ignored.
- ARM: at next falling tick, MDIO_OE=1, MDIO_OUT=T_DATA[31], bit_cnt=0, → DRIVE.
- DRIVE: each subsequent falling tick increments bit_cnt and presents next bit.
  - op_rd=0 (OP 01, and also 00/11): drives all 32 bits; at falling tick ending bit 31: MDIO_OE=0, MDIO_OUT=0, BUSY=0, → IDLE. No DATA_RDY.
  - op_rd=1: after bit 15 (end of TA), at that falling tick MDIO_OE=0, MDIO_OUT=0, → RELEASE_RD.
- RELEASE_RD: on each of the next 16 falling ticks, MDIO_IN shifted into internal capture reg (MSB first). On the 16th: RD_DATA=captured word, DATA_RDY=1 for that one CLK cycle, BUSY=0, → IDLE.
- RD_DATA holds value until next completed read; writes never change it.
- MDIO_IN ignored outside RELEASE_RD.

## Timing
- MDIO_OUT/MDIO_OE change only on falling ticks; receiver samples on MDC rising edge, giving ≥MDC_HALF CLK setup/hold.
- MDIO_IN sampled on falling ticks, half an MDC period after PHY updates on rising edge.
- START→first bit: 1 to 2·MDC_HALF+1 CLK cycles (waits for next falling tick).
- Write frame: MDIO_OE high exactly 32 MDC periods (64 CLK at MDC_HALF=1).
- Read frame: MDIO_OE high 16 MDC periods, then low; DATA_RDY at 32 MDC periods after first falling tick.
- Back-to-back: START accepted the CLK edge after BUSY falls; DATA_RDY and BUSY fall on the same edge.
- MDC keeps toggling in IDLE; no bits driven.

## Test plan
- Reset: hold RESET=0 5 cycles with START=1 → all outputs 0, MDC static 0, BUSY=0.
- Write: T_DATA=32'h500E_ABCD, START 1 cycle → MDIO_OE high 64 CLK, MDIO_OUT serialises 0x500EABCD MSB first on falling ticks; receptor model reports ADDR=3, WR_DATA=16'hABCD; DATA_RDY never 1, RD_DATA unchanged.
- Read: T_DATA=32'h600E_0000, PHY model returns 16'hAAAA → OE high for bits 0x600E only, then 0; RD_DATA=16'hAAAA, DATA_RDY single-cycle pulse, BUSY falls same edge.
- START while busy: pulse START with 32'h600E_0000 mid-write → ignored; write completes unaltered, no read follows.
- Reset mid-read: RESET=0 at bit 20 → next edge all outputs reset, RD_DATA=0, no DATA_RDY; subsequent read returns correct data.
- MDC_HALF=3: read of 16'h1234 → MDC period 6 CLK, outputs change only on falling ticks, RD_DATA=16'h1234.

Source files
------------

// File: rtl/mdio_controller.sv
// rtl/mdio_controller.sv - host-side MDIO frame generator with self-generated MDC
module mdio_controller #(
  parameter int MDC_HALF = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MDIO_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  localparam int DIV_W = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_HALF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_DRIVE,
    S_RELEASE_RD
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              mdc_q, mdc_d;
  logic [31:0]       shift_q, shift_d;
  logic              op_rd_q, op_rd_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [15:0]       cap_q, cap_d;
  logic              mdio_out_q, mdio_out_d;
  logic              mdio_oe_q, mdio_oe_d;
  logic [15:0]       rd_data_q, rd_data_d;
  logic              data_rdy_q, data_rdy_d;
  logic              busy_q, busy_d;
  logic              div_wrap;
  logic              fall_tick;

  // Next-state: MDC divider plus frame sequencing; all bus activity on falling ticks
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    mdc_d      = mdc_q;
    shift_d    = shift_q;
    op_rd_d    = op_rd_q;
    bit_cnt_d  = bit_cnt_q;
    cap_d      = cap_q;
    mdio_out_d = mdio_out_q;
    mdio_oe_d  = mdio_oe_q;
    rd_data_d  = rd_data_q;
    data_rdy_d = 1'b0;
    busy_d     = busy_q;

    div_wrap  = (div_cnt_q == DIV_LAST);
    fall_tick = div_wrap && mdc_q;

    if (div_wrap) begin
      div_cnt_d = '0;
      mdc_d     = ~mdc_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (MDIO_START) begin
          shift_d = T_DATA;
          op_rd_d = (T_DATA[29:28] == 2'b10);
          busy_d  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (fall_tick) begin
          mdio_oe_d  = 1'b1;
          mdio_out_d = shift_q[31];
          shift_d    = {shift_q[30:0], 1'b0};
          bit_cnt_d  = 5'd0;
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (fall_tick) begin
          // A read hands the bus to the PHY after TA; anything else runs 32 bits
          if ((op_rd_q && bit_cnt_q == 5'd15) || (!op_rd_q && bit_cnt_q == 5'd31)) begin
            mdio_oe_d  = 1'b0;
            mdio_out_d = 1'b0;
            bit_cnt_d  = 5'd0;
            if (op_rd_q) begin
              state_d = S_RELEASE_RD;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + 5'd1;
            mdio_out_d = shift_q[31];
            shift_d    = {shift_q[30:0], 1'b0};
          end
        end
      end
      S_RELEASE_RD: begin
        if (fall_tick) begin
          cap_d     = {cap_q[14:0], MDIO_IN};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            rd_data_d  = {cap_q[14:0], MDIO_IN};
            data_rdy_d = 1'b1;
            busy_d     = 1'b0;
            bit_cnt_d  = 5'd0;
            state_d    = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset abandons any frame
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      mdc_q      <= 1'b0;
      shift_q    <= 32'd0;
      op_rd_q    <= 1'b0;
      bit_cnt_q  <= 5'd0;
      cap_q      <= 16'd0;
      mdio_out_q <= 1'b0;
      mdio_oe_q  <= 1'b0;
      rd_data_q  <= 16'd0;
      data_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      mdc_q      <= mdc_d;
      shift_q    <= shift_d;
      op_rd_q    <= op_rd_d;
      bit_cnt_q  <= bit_cnt_d;
      cap_q      <= cap_d;
      mdio_out_q <= mdio_out_d;
      mdio_oe_q  <= mdio_oe_d;
      rd_data_q  <= rd_data_d;
      data_rdy_q <= data_rdy_d;
      busy_q     <= busy_d;
    end
  end

  assign MDC      = mdc_q;
  assign MDIO_OUT = mdio_out_q;
  assign MDIO_OE  = mdio_oe_q;
  assign RD_DATA  = rd_data_q;
  assign DATA_RDY = data_rdy_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// tb/tb_mdio_controller.sv - randomized self-checking bench for mdio_controller
module tb_mdio_controller;

  logic        clk;
  logic        resetn  [2];
  logic        start   [2];
  logic [31:0] tdata   [2];
  logic        mdio_in [2];
  logic        mdc     [2];
  logic        mout    [2];
  logic        moe     [2];
  logic [15:0] rd      [2];
  logic        rdy     [2];
  logic        busy    [2];

  int n_checks = 0;
  int n_fail   = 0;

  // receiver / PHY model state, written only by the monitor process
  int          mon_bits  [2] = '{0, 0};
  logic [31:0] mon_frame [2] = '{32'd0, 32'd0};
  int          rdy_cnt   [2] = '{0, 0};
  int          viol      [2] = '{0, 0};
  int          phy_cnt   [2] = '{0, 0};
  bit          phy_act   [2] = '{1'b0, 1'b0};
  logic        rdy_busy  [2] = '{1'b0, 1'b0};
  logic        mdc_p     [2] = '{1'b0, 1'b0};
  logic        oe_p      [2] = '{1'b0, 1'b0};
  logic        out_p     [2] = '{1'b0, 1'b0};

  // main-thread state
  logic [15:0] phy_data  [2];
  logic [15:0] exp_rd    [2];

  mdio_controller #(.MDC_HALF(1)) u_dut1 (
    .CLK(clk), .RESET(resetn[0]), .MDIO_START(start[0]), .T_DATA(tdata[0]),
    .MDIO_IN(mdio_in[0]), .MDC(mdc[0]), .MDIO_OUT(mout[0]), .MDIO_OE(moe[0]),
    .RD_DATA(rd[0]), .DATA_RDY(rdy[0]), .BUSY(busy[0])
  );

  mdio_controller #(.MDC_HALF(3)) u_dut3 (
    .CLK(clk), .RESET(resetn[1]), .MDIO_START(start[1]), .T_DATA(tdata[1]),
    .MDIO_IN(mdio_in[1]), .MDC(mdc[1]), .MDIO_OUT(mout[1]), .MDIO_OE(moe[1]),
    .RD_DATA(rd[1]), .DATA_RDY(rdy[1]), .BUSY(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Receiver samples on MDC rise; PHY answers reads on MDC rise after the 16 command bits
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      if (!resetn[g]) begin
        phy_act[g] = 1'b0;
        phy_cnt[g] = 0;
        mdio_in[g] = 1'b0;
      end else begin
        if (moe[g] && !oe_p[g]) begin
          mon_bits[g]  = 0;
          mon_frame[g] = 32'd0;
        end
        if (mdc[g] && !mdc_p[g]) begin
          if (phy_act[g]) begin
            mdio_in[g] = phy_data[g][4'(15 - phy_cnt[g])];
            phy_cnt[g]++;
            if (phy_cnt[g] == 16) phy_act[g] = 1'b0;
          end else begin
            mdio_in[g] = 1'($urandom);
          end
          if (moe[g]) begin
            mon_frame[g] = {mon_frame[g][30:0], mout[g]};
            mon_bits[g]++;
            if (mon_bits[g] == 16 && mon_frame[g][13:12] == 2'b10) begin
              phy_act[g] = 1'b1;
              phy_cnt[g] = 0;
            end
          end
        end
        if ((moe[g] != oe_p[g] || mout[g] != out_p[g]) && !(mdc_p[g] && !mdc[g]))
          viol[g]++;
        if (rdy[g]) begin
          rdy_cnt[g]++;
          rdy_busy[g] = busy[g];
        end
      end
      mdc_p[g] = mdc[g];
      oe_p[g]  = moe[g];
      out_p[g] = mout[g];
    end
  end

  task automatic run_frame(input int g, input logic [31:0] td, input logic [15:0] ret,
                           input int mid_at, input int rst_at);
    int h, n, lat, oe_len, rdy_at, busy_at, rdy0;
    bit is_rd, done;
    h      = (g == 0) ? 1 : 3;
    is_rd  = (td[29:28] == 2'b10);
    phy_data[g] = ret;
    rdy0   = rdy_cnt[g];
    start[g] = 1'b1;
    tdata[g] = td;
    @(negedge clk);
    start[g] = 1'b0;
    tdata[g] = $urandom;
    check("busy_on_accept", 32'(busy[g]), 32'd1);
    lat = 0;
    while (!moe[g] && lat < 4 * h + 4) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", 32'(lat >= 1 && lat <= 2 * h + 1), 32'd1);
    n = 0; oe_len = -1; rdy_at = -1; busy_at = -1; done = 1'b0;
    while (!done && n < 80 * h) begin
      start[g] = (n == mid_at);
      if (n == mid_at) tdata[g] = 32'h600E_0000;
      if (n == rst_at) resetn[g] = 1'b0;
      @(negedge clk);
      n++;
      if (!resetn[g]) begin
        resetn[g] = 1'b1;
        start[g]  = 1'b0;
        check("rst_mdc", 32'(mdc[g]), 32'd0);
        check("rst_oe", 32'(moe[g]), 32'd0);
        check("rst_out", 32'(mout[g]), 32'd0);
        check("rst_busy", 32'(busy[g]), 32'd0);
        check("rst_rd_data", 32'(rd[g]), 32'd0);
        check("rst_no_rdy", 32'(rdy_cnt[g] - rdy0), 32'd0);
        exp_rd[g] = 16'd0;
        return;
      end
      if (oe_len < 0 && !moe[g]) oe_len = n;
      if (rdy_at < 0 && rdy[g]) rdy_at = n;
      if (!busy[g]) begin
        busy_at = n;
        done = 1'b1;
      end
    end
    start[g] = 1'b0;
    check("frame_bits", 32'(mon_bits[g]), is_rd ? 32'd16 : 32'd32);
    if (is_rd) check("frame_cmd", {16'd0, mon_frame[g][15:0]}, {16'd0, td[31:16]});
    else       check("frame_word", mon_frame[g], td);
    check("oe_len", 32'(oe_len), 32'(is_rd ? 32 * h : 64 * h));
    check("busy_end", 32'(busy_at), 32'(64 * h));
    if (is_rd) begin
      exp_rd[g] = ret;
      check("rdy_time", 32'(rdy_at), 32'(64 * h));
      check("rdy_pulses", 32'(rdy_cnt[g] - rdy0), 32'd1);
      check("busy_with_rdy", 32'(rdy_busy[g]), 32'd0);
    end else begin
      check("no_rdy_on_write", 32'(rdy_cnt[g] - rdy0), 32'd0);
    end
    check("rd_data", 32'(rd[g]), 32'(exp_rd[g]));
  endtask

  initial begin
    logic [31:0] td;
    bit mdc_hi [2];
    bit any_hi [2];
    for (int g = 0; g < 2; g++) begin
      resetn[g] = 1'b0;
      start[g]  = 1'b1;
      tdata[g]  = $urandom;
      phy_data[g] = 16'd0;
      exp_rd[g]   = 16'd0;
      mdc_hi[g] = 1'b0;
      any_hi[g] = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        mdc_hi[g] |= mdc[g];
        any_hi[g] |= mout[g] | moe[g] | rdy[g] | busy[g] | (rd[g] != 16'd0);
      end
    end
    for (int g = 0; g < 2; g++) begin
      check("reset_mdc_static", 32'(mdc_hi[g]), 32'd0);
      check("reset_outputs", 32'(any_hi[g]), 32'd0);
      check("reset_busy", 32'(busy[g]), 32'd0);
      check("reset_rd_data", 32'(rd[g]), 32'd0);
      resetn[g] = 1'b1;
      start[g]  = 1'b0;
    end
    repeat (3) @(negedge clk);

    run_frame(0, 32'h500E_ABCD, 16'h0000, -1, -1);
    check("wr_regad", 32'(mon_frame[0][22:18]), 32'd3);
    check("wr_data", 32'(mon_frame[0][15:0]), 32'hABCD);
    run_frame(0, 32'h600E_0000, 16'hAAAA, -1, -1);
    run_frame(0, 32'h5000_1234 | ($urandom & 32'h0FFC_FFFF), 16'h0000, 20, -1);
    repeat (10) @(negedge clk);
    check("no_read_follows_busy", 32'(busy[0]), 32'd0);
    check("no_read_follows_oe", 32'(moe[0]), 32'd0);
    run_frame(0, 32'h600E_0000, 16'h5A5A, -1, 2 * 20 + 1);
    repeat (2) @(negedge clk);
    run_frame(0, 32'h6112_0000, 16'hC3E1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      td = $urandom;
      td[29:28] = (i % 2 == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      run_frame(0, td, 16'($urandom), -1, -1);
    end

    run_frame(1, 32'h600E_0000, 16'h1234, -1, -1);
    for (int i = 0; i < 4; i++) begin
      td = $urandom;
      td[29:28] = (i % 2 == 0) ? 2'b01 : 2'b10;
      run_frame(1, td, 16'($urandom), -1, -1);
    end

    repeat (4) @(negedge clk);
    check("oe_out_on_fall_h1", 32'(viol[0]), 32'd0);
    check("oe_out_on_fall_h3", 32'(viol[1]), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
